// File: rtl/video_lock_seq.sv
// video_lock_seq: qualifies PLL lock, sequences video-domain reset release and pixel clock enable
// Ports:
//   clk125        125 MHz PLL clock, the only clock
//   rst_n         asynchronous active-low reset
//   locked        PLL lock, asynchronous to clk125
//   rst_out_n     video-domain reset, low = held in reset
//   pix_ce        single-cycle pixel clock enable, one in DIV cycles
//   phase         position within the DIV cycle
//   ready         copy of rst_out_n
//   lock_lost_cnt saturating count of lock losses while running
module video_lock_seq #(
    parameter int STABLE_CYCLES = 1024,
    parameter int DIV = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk125,
    input  logic       rst_n,
    input  logic       locked,
    output logic       rst_out_n,
    output logic       pix_ce,
    output logic [2:0] phase,
    output logic       ready,
    output logic [7:0] lock_lost_cnt
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [2:0] PMAX = 3'(DIV - 1);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

    if (DIV < 2 || DIV > 8 || STABLE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
        $error("video_lock_seq: illegal DIV, STABLE_CYCLES or SYNC_STAGES");
    end

    typedef enum logic [1:0] {WAIT_LOCK, COUNT, RELEASE, RUN} state_t;

    state_t state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [2:0] nphase;
    logic [SYNC_STAGES-1:0] sync;
    logic lock_s;

    assign lock_s = sync[SYNC_STAGES-1];
    assign ready = rst_out_n;

    // Any lock_s drop returns to WAIT_LOCK with counters cleared, taking
    // priority over the COUNT and RELEASE terminal transitions.
    always_comb begin
        nstate = state;
        ncnt = cnt;
        nphase = phase;
        case (state)
            WAIT_LOCK: begin
                ncnt = '0;
                nphase = '0;
                nstate = lock_s ? COUNT : WAIT_LOCK;
            end
            COUNT: begin
                if (!lock_s) begin
                    nstate = WAIT_LOCK;
                    ncnt = '0;
                end else if (cnt == CMAX) begin
                    nstate = RELEASE;
                    ncnt = '0;
                    nphase = '0;
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    nstate = WAIT_LOCK;
                    nphase = '0;
                end else if (phase == PMAX) begin
                    nstate = RUN;
                    nphase = '0;
                end else begin
                    nphase = phase + 3'd1;
                end
            end
            RUN: begin
                nstate = lock_s ? RUN : WAIT_LOCK;
                nphase = !lock_s || phase == PMAX ? 3'd0 : phase + 3'd1;
            end
            default: begin
                nstate = WAIT_LOCK;
                ncnt = '0;
                nphase = '0;
            end
        endcase
    end

    // rst_out_n and pix_ce are registered from the next-state values so they
    // never glitch and line up with the state/phase they describe.
    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            state <= WAIT_LOCK;
            cnt <= '0;
            phase <= '0;
            rst_out_n <= 1'b0;
            pix_ce <= 1'b0;
            lock_lost_cnt <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], locked};
            state <= nstate;
            cnt <= ncnt;
            phase <= nphase;
            rst_out_n <= nstate == RUN;
            pix_ce <= (nstate == RELEASE || nstate == RUN) && nphase == PMAX;
            if (state == RUN && !lock_s && lock_lost_cnt != 8'hff)
                lock_lost_cnt <= lock_lost_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_video_lock_seq.sv
// tb_video_lock_seq: randomized self-checking bench for video_lock_seq against a lock-history model
module tb_video_lock_seq;
    localparam int S = 16;
    localparam int D = 5;
    localparam int RISE = 2 + 1 + S + D;

    logic clk125 = 1'b0;
    logic rst_n = 1'b0;
    logic locked = 1'b0;
    logic clk_en = 1'b1;
    logic rst_out_n, pix_ce, ready;
    logic [2:0] phase;
    logic [7:0] lock_lost_cnt;

    int n_checks = 0;
    int n_fail = 0;
    // h = consecutive clock edges that have seen synchronized lock high
    int h = 0;
    int lost = 0;
    bit l1 = 1'b0;
    bit l2 = 1'b0;

    video_lock_seq #(.STABLE_CYCLES(S), .DIV(D), .SYNC_STAGES(2)) dut (
        .clk125(clk125),
        .rst_n(rst_n),
        .locked(locked),
        .rst_out_n(rst_out_n),
        .pix_ce(pix_ce),
        .phase(phase),
        .ready(ready),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always begin
        #4;
        if (clk_en) clk125 = ~clk125;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        h = 0;
        lost = 0;
        l1 = 1'b0;
        l2 = 1'b0;
    endtask

    // Lock seen by the sequencer at an edge is the raw lock sampled two edges earlier.
    task automatic model_step();
        bit ls;
        if (!rst_n) begin
            model_clear();
            return;
        end
        ls = l2;
        l2 = l1;
        l1 = locked;
        if (ls) h++;
        else begin
            if (h > S + D && lost < 255) lost++;
            h = 0;
        end
    endtask

    task automatic check_all();
        int ph;
        ph = h > S ? (h - S - 1) % D : 0;
        check("rst_out_n", int'(rst_out_n), int'(h > S + D));
        check("ready", int'(ready), int'(h > S + D));
        check("pix_ce", int'(pix_ce), int'(h > S && ph == D - 1));
        check("phase", int'(phase), ph);
        check("lock_lost_cnt", int'(lock_lost_cnt), lost);
    endtask

    task automatic check_reset_outputs();
        check("async_rst_out_n", int'(rst_out_n), 0);
        check("async_ready", int'(ready), 0);
        check("async_pix_ce", int'(pix_ce), 0);
        check("async_phase", int'(phase), 0);
        check("async_lock_lost_cnt", int'(lock_lost_cnt), 0);
    endtask

    task automatic cyc(input bit lk);
        locked = lk;
        @(posedge clk125);
        model_step();
        #1 check_all();
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (n < 100 && !rst_out_n) begin
            cyc(1'b1);
            n++;
        end
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (n < 100 && rst_out_n) begin
            cyc(1'b0);
            n++;
        end
    endtask

    task automatic restart();
        rst_n = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (6) cyc(1'b1);
        rst_n = 1'b1;
        wait_rise(n);
        check("startup_edges", n, RISE);
        repeat (12) cyc(1'b1);

        @(negedge clk125) clk_en = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_clear();
        #5 clk_en = 1'b1;
        repeat (3) cyc(1'b1);

        rst_n = 1'b1;
        repeat (8) cyc(1'b1);
        repeat (3) cyc(1'b0);
        wait_rise(n);
        check("relock_after_count_glitch", n, RISE);
        check("count_glitch_no_loss", int'(lock_lost_cnt), 0);

        repeat (10) cyc(1'b1);
        wait_fall(n);
        check("loss_edges", n, 3);
        check("loss_cnt", int'(lock_lost_cnt), 1);
        wait_rise(n);
        check("relock_edges", n, RISE);

        for (int k = 15; k <= 25; k++) begin
            restart();
            repeat (k - 1) cyc(1'b1);
            cyc(1'b0);
            repeat (30) cyc(1'b1);
        end

        restart();
        repeat (40) begin
            repeat ($urandom_range(1, 35)) cyc(1'b1);
            repeat ($urandom_range(1, 4)) cyc(1'b0);
        end

        restart();
        repeat (300) begin
            wait_rise(n);
            check("loop_rise_edges", n, RISE);
            cyc(1'b1);
            wait_fall(n);
        end
        check("lost_saturated", int'(lock_lost_cnt), 255);

        restart();
        repeat (7) begin
            wait_rise(n);
            cyc(1'b1);
            wait_fall(n);
        end
        wait_rise(n);
        repeat (4) cyc(1'b1);
        check("pre_reset_cnt", int'(lock_lost_cnt), 7);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        model_clear();
        cyc(1'b1);
        rst_n = 1'b1;
        wait_rise(n);
        check("post_reset_startup_edges", n, RISE);
        repeat (12) cyc(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
